// File: rtl/approx_csr_bank.sv
// Approximation-control CSR bank: N_CSR read/write control registers at
// BASE_INDEX..BASE_INDEX+N_CSR-1 with write / set-bits / clear-bits ops,
// combinational reads, a flattened bank output and a registered
// illegal-access pulse.
// Optional feature macro: APPROX_CSR_COUNTERS_EN adds 64-bit read-only cycle
// and instret counters at 12'hC00/12'hC80 and 12'hC02/12'hC82.
// With XLEN=64 the low index returns the whole counter and the high index is
// unmapped.
module approx_csr_bank #(
   parameter int          N_CSR      = 3,
   parameter logic [11:0] BASE_INDEX = 12'h800,
   parameter int          XLEN       = 32
) (
   input  logic                    CLK,
   input  logic                    reset,
   input  logic                    read_enable_csr,
   input  logic [11:0]             csr_read_index,
   output logic [XLEN-1:0]         csr_read_data,
   input  logic [1:0]              csr_op,
   input  logic [11:0]             csr_write_index,
   input  logic [XLEN-1:0]         csr_write_data,
   input  logic                    instret_inc,
   output logic [N_CSR*XLEN-1:0]   csr_bank_out,
   output logic                    csr_illegal
);

   localparam logic [1:0] OP_NONE  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_SET   = 2'b10;
   localparam logic [1:0] OP_CLR   = 2'b11;

   logic [XLEN-1:0] csr_q [N_CSR];
   logic            w_csr_hit;
   logic            r_csr_hit;
   logic            w_ctr_hit;
   logic            r_ctr_hit;
   logic [XLEN-1:0] ctr_rdata;
   logic            illegal_d;
   logic            illegal_q;

   function automatic logic [XLEN-1:0] apply_op(input logic [1:0]      op,
                                                input logic [XLEN-1:0] old_v,
                                                input logic [XLEN-1:0] data);
      case (op)
         OP_WRITE: return data;
         OP_SET:   return old_v | data;
         OP_CLR:   return old_v & ~data;
         default:  return old_v;
      endcase
   endfunction

   // Address decode for the control CSR range, read and write ports.
   always_comb begin
      w_csr_hit = 1'b0;
      r_csr_hit = 1'b0;
      for (int k = 0; k < N_CSR; k++) begin
         if (csr_write_index == BASE_INDEX + 12'(k)) w_csr_hit = 1'b1;
         if (csr_read_index == BASE_INDEX + 12'(k))  r_csr_hit = 1'b1;
      end
   end

`ifdef APPROX_CSR_COUNTERS_EN
   // The high halves exist only when a counter does not fit in one CSR.
   localparam bit HI_MAP = (XLEN == 32);

   logic [63:0] cycle_q;
   logic [63:0] instret_q;

   // Free-running cycle counter and retired-instruction counter; both wrap.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         cycle_q   <= 64'd0;
         instret_q <= 64'd0;
      end else begin
         cycle_q   <= cycle_q + 64'd1;
         instret_q <= instret_q + 64'(instret_inc);
      end
   end

   assign w_ctr_hit = (csr_write_index == 12'hC00) || (csr_write_index == 12'hC02) ||
                      (HI_MAP && ((csr_write_index == 12'hC80) || (csr_write_index == 12'hC82)));
   assign r_ctr_hit = (csr_read_index == 12'hC00) || (csr_read_index == 12'hC02) ||
                      (HI_MAP && ((csr_read_index == 12'hC80) || (csr_read_index == 12'hC82)));

   // Counter read mux; low index gives the low XLEN bits of the counter.
   always_comb begin
      ctr_rdata = '0;
      case (csr_read_index)
         12'hC00: ctr_rdata = XLEN'(cycle_q);
         12'hC02: ctr_rdata = XLEN'(instret_q);
         12'hC80: if (HI_MAP) ctr_rdata = XLEN'(cycle_q >> 32);
         12'hC82: if (HI_MAP) ctr_rdata = XLEN'(instret_q >> 32);
         default: ctr_rdata = '0;
      endcase
   end
`else
   logic unused_instret;
   assign unused_instret = instret_inc;
   assign w_ctr_hit      = 1'b0;
   assign r_ctr_hit      = 1'b0;
   assign ctr_rdata      = '0;
`endif

   // Combinational read port; anything unqualified or unmapped reads as 0.
   always_comb begin
      csr_read_data = '0;
      if (read_enable_csr) begin
         for (int k = 0; k < N_CSR; k++) begin
            if (csr_read_index == BASE_INDEX + 12'(k)) csr_read_data = csr_q[k];
         end
         if (r_ctr_hit) csr_read_data = ctr_rdata;
      end
   end

   // Illegal access: unmapped op or read, a write to a counter, or a
   // set/clear on a counter that would change bits.
   always_comb begin
      illegal_d = 1'b0;
      if ((csr_op != OP_NONE) && !w_csr_hit && !w_ctr_hit)              illegal_d = 1'b1;
      if (read_enable_csr && !r_csr_hit && !r_ctr_hit)                  illegal_d = 1'b1;
      if (w_ctr_hit && (csr_op == OP_WRITE))                            illegal_d = 1'b1;
      if (w_ctr_hit && csr_op[1] && (csr_write_data != '0))             illegal_d = 1'b1;
   end

   // Control CSR storage; only a mapped control index is ever written.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < N_CSR; k++) csr_q[k] <= '0;
      end else begin
         for (int k = 0; k < N_CSR; k++) begin
            if ((csr_op != OP_NONE) && (csr_write_index == BASE_INDEX + 12'(k)))
               csr_q[k] <= apply_op(csr_op, csr_q[k], csr_write_data);
         end
      end
   end

   // One-cycle illegal pulse, registered from the access decode.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) illegal_q <= 1'b0;
      else        illegal_q <= illegal_d;
   end

   assign csr_illegal = illegal_q;

   for (genvar k = 0; k < N_CSR; k++) begin : g_flat
      assign csr_bank_out[k*XLEN +: XLEN] = csr_q[k];
   end

endmodule

// File: tb/tb_approx_csr_bank.sv
// Bench for approx_csr_bank (default parameters). A reference model of the
// register map is checked against the DUT at every falling edge; directed
// sequences add hand-computed expectations. Counter checks are compiled in
// when APPROX_CSR_COUNTERS_EN is defined.
module tb_approx_csr_bank;

   localparam int N    = 3;
   localparam int XL   = 32;
   localparam int BASE = 'h800;

   logic            CLK;
   logic            reset;
   logic            read_enable_csr;
   logic [11:0]     csr_read_index;
   logic [XL-1:0]   csr_read_data;
   logic [1:0]      csr_op;
   logic [11:0]     csr_write_index;
   logic [XL-1:0]   csr_write_data;
   logic            instret_inc;
   logic [N*XL-1:0] csr_bank_out;
   logic            csr_illegal;

   int n_total = 0;
   int n_pass  = 0;

   logic [31:0] m_csr [N];
   logic        m_illegal;
   logic [63:0] m_ticks;
   logic [63:0] m_instret;
   logic [63:0] m_cyc_adj;

   approx_csr_bank #(.N_CSR(N), .BASE_INDEX(12'h800), .XLEN(XL)) dut (
      .CLK             (CLK),
      .reset           (reset),
      .read_enable_csr (read_enable_csr),
      .csr_read_index  (csr_read_index),
      .csr_read_data   (csr_read_data),
      .csr_op          (csr_op),
      .csr_write_index (csr_write_index),
      .csr_write_data  (csr_write_data),
      .instret_inc     (instret_inc),
      .csr_bank_out    (csr_bank_out),
      .csr_illegal     (csr_illegal)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic bit is_csr(input int idx);
      return (idx >= BASE) && (idx < BASE + N);
   endfunction

   function automatic bit is_ctr(input int idx);
`ifdef APPROX_CSR_COUNTERS_EN
      return (idx == 'hC00) || (idx == 'hC80) || (idx == 'hC02) || (idx == 'hC82);
`else
      return (idx < 0);
`endif
   endfunction

   function automatic bit m_bad(input logic [1:0] op, input int widx, input logic [31:0] wd,
                                input logic re, input int ridx);
      bit b;
      b = 1'b0;
      if (op != 0 && !is_csr(widx) && !is_ctr(widx)) b = 1'b1;
      if (re && !is_csr(ridx) && !is_ctr(ridx))       b = 1'b1;
      if (is_ctr(widx) && (op == 1 || (op >= 2 && wd != 0))) b = 1'b1;
      return b;
   endfunction

   function automatic logic [31:0] m_new(input logic [1:0] op, input logic [31:0] o, input logic [31:0] d);
      if (op == 1) return d;
      if (op == 2) return o | d;
      if (op == 3) return o & ~d;
      return o;
   endfunction

   function automatic logic [31:0] m_read(input logic re, input int idx);
      logic [63:0] cyc;
      cyc = m_ticks + m_cyc_adj;
      if (!re) return 32'd0;
      if (is_csr(idx)) return m_csr[idx - BASE];
      if (is_ctr(idx)) begin
         if (idx == 'hC00) return cyc[31:0];
         if (idx == 'hC80) return cyc[63:32];
         if (idx == 'hC02) return m_instret[31:0];
         return m_instret[63:32];
      end
      return 32'd0;
   endfunction

   function automatic logic [N*XL-1:0] m_flat();
      logic [N*XL-1:0] f;
      for (int k = 0; k < N; k++) f[k*XL +: XL] = m_csr[k];
      return f;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: register state follows the access rules edge by edge.
   always @(posedge CLK or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < N; k++) m_csr[k] <= 32'd0;
         m_illegal <= 1'b0;
         m_ticks   <= 64'd0;
         m_instret <= 64'd0;
      end else begin
         m_illegal <= m_bad(csr_op, int'(csr_write_index), csr_write_data,
                            read_enable_csr, int'(csr_read_index));
         if (csr_op != 0 && is_csr(int'(csr_write_index)))
            m_csr[int'(csr_write_index) - BASE] <=
               m_new(csr_op, m_csr[int'(csr_write_index) - BASE], csr_write_data);
         m_ticks <= m_ticks + 64'd1;
         if (instret_inc) m_instret <= m_instret + 64'd1;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge CLK) begin
      check("read_data", 128'(csr_read_data), 128'(m_read(read_enable_csr, int'(csr_read_index))));
      check("bank_out", 128'(csr_bank_out), 128'(m_flat()));
      check("illegal", 128'(csr_illegal), 128'(m_illegal));
   end

   task automatic drive(input logic [1:0] op, input logic [11:0] widx, input logic [31:0] wd,
                        input logic re, input logic [11:0] ridx);
      @(posedge CLK);
      #1;
      csr_op          = op;
      csr_write_index = widx;
      csr_write_data  = wd;
      read_enable_csr = re;
      csr_read_index  = ridx;
   endtask

   initial begin
      m_cyc_adj       = 64'd0;
      reset           = 1'b0;
      read_enable_csr = 1'b0;
      csr_read_index  = 12'h000;
      csr_op          = 2'b00;
      csr_write_index = 12'h000;
      csr_write_data  = 32'd0;
      instret_inc     = 1'b0;
      #2;
      check("reset_bank", 128'(csr_bank_out), 128'd0);
      check("reset_illegal", 128'(csr_illegal), 128'd0);
      #21 reset = 1'b1;

      // write then set bits
      drive(2'b01, 12'h800, 32'h0000_00F0, 1'b0, 12'h000);
      drive(2'b10, 12'h800, 32'h0000_000F, 1'b1, 12'h800);
      @(negedge CLK);
      check("pre_set_read", 128'(csr_read_data), 128'h0000_00F0);
      drive(2'b00, 12'h000, 32'h0, 1'b1, 12'h800);
      @(negedge CLK);
      check("set_read", 128'(csr_read_data), 128'h0000_00FF);
      check("set_bank", 128'(csr_bank_out[31:0]), 128'h0000_00FF);

      // clear bits with same-cycle read
      drive(2'b11, 12'h800, 32'h0000_0003, 1'b1, 12'h800);
      @(negedge CLK);
      check("clr_same_cycle", 128'(csr_read_data), 128'h0000_00FF);
      drive(2'b00, 12'h000, 32'h0, 1'b1, 12'h800);
      @(negedge CLK);
      check("clr_next_cycle", 128'(csr_read_data), 128'h0000_00FC);

      // fill the other CSRs
      drive(2'b01, 12'h801, 32'h1234_5678, 1'b0, 12'h000);
      drive(2'b01, 12'h802, 32'hA5A5_5A5A, 1'b1, 12'h801);
      drive(2'b11, 12'h802, 32'hFFFF_0000, 1'b1, 12'h802);
      drive(2'b00, 12'h000, 32'h0, 1'b1, 12'h802);
      @(negedge CLK);
      check("clr_802", 128'(csr_read_data), 128'h0000_5A5A);

      // write to unmapped 803
      drive(2'b01, 12'h803, 32'hFFFF_FFFF, 1'b1, 12'h803);
      @(negedge CLK);
      check("read_803", 128'(csr_read_data), 128'd0);
      drive(2'b00, 12'h000, 32'h0, 1'b0, 12'h000);
      @(negedge CLK);
      check("illegal_803", 128'(csr_illegal), 128'd1);
      check("bank_after_803", 128'(csr_bank_out), {32'd0, 32'h0000_5A5A, 32'h1234_5678, 32'h0000_00FC});
      drive(2'b00, 12'h000, 32'h0, 1'b0, 12'h000);
      @(negedge CLK);
      check("illegal_803_drop", 128'(csr_illegal), 128'd0);

      // assorted legal and illegal accesses
      drive(2'b10, 12'h900, 32'h1, 1'b0, 12'h000);
      drive(2'b00, 12'h000, 32'h0, 1'b1, 12'h7FF);
      drive(2'b00, 12'h000, 32'h0, 1'b1, 12'hC00);
      drive(2'b11, 12'hC02, 32'h0, 1'b1, 12'h801);
      drive(2'b10, 12'h801, 32'h0F00_0000, 1'b1, 12'h801);
      drive(2'b00, 12'h000, 32'h0, 1'b1, 12'h801);
      @(negedge CLK);
      check("set_801", 128'(csr_read_data), 128'h1F34_5678);

      // asynchronous reset mid-cycle
      drive(2'b01, 12'h801, 32'hDEAD_BEEF, 1'b0, 12'h000);
      drive(2'b00, 12'h000, 32'h0, 1'b1, 12'h801);
      @(negedge CLK);
      check("deadbeef", 128'(csr_read_data), 128'hDEAD_BEEF);
      #2 reset = 1'b0;
      #1;
      check("async_bank", 128'(csr_bank_out), 128'd0);
      check("async_read", 128'(csr_read_data), 128'd0);
      csr_op          = 2'b01;
      csr_write_index = 12'h801;
      csr_write_data  = 32'h0000_0055;
      @(posedge CLK);
      #1;
      check("write_in_reset", 128'(csr_bank_out), 128'd0);
      #1 reset = 1'b1;
      #1;
      check("deassert_no_edge", 128'(csr_bank_out), 128'd0);
      @(posedge CLK);
      #1;
      check("first_edge_write", 128'(csr_bank_out[63:32]), 128'h0000_0055);
      csr_op          = 2'b00;
      read_enable_csr = 1'b0;

`ifdef APPROX_CSR_COUNTERS_EN
      drive(2'b00, 12'h000, 32'h0, 1'b1, 12'hC02);
      instret_inc = 1'b1;
      drive(2'b00, 12'h000, 32'h0, 1'b1, 12'hC82);
      drive(2'b00, 12'h000, 32'h0, 1'b1, 12'hC02);
      instret_inc = 1'b0;
      drive(2'b00, 12'h000, 32'h0, 1'b1, 12'hC00);
      @(negedge CLK);
      #1;
      force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
      m_cyc_adj = 64'h0000_0000_FFFF_FFFF - m_ticks;
      #1 release dut.cycle_q;
      @(posedge CLK);
      #1;
      check("cycle_lo_wrap", 128'(csr_read_data), 128'd0);
      csr_read_index = 12'hC80;
      #1;
      check("cycle_hi_carry", 128'(csr_read_data), 128'd1);
      drive(2'b01, 12'hC00, 32'h5, 1'b0, 12'h000);
      drive(2'b00, 12'h000, 32'h0, 1'b0, 12'h000);
      @(negedge CLK);
      check("ctr_write_illegal", 128'(csr_illegal), 128'd1);
      drive(2'b10, 12'hC02, 32'h0, 1'b1, 12'hC80);
      drive(2'b00, 12'h000, 32'h0, 1'b0, 12'h000);
      @(negedge CLK);
      check("ctr_set_zero_legal", 128'(csr_illegal), 128'd0);
`endif

      drive(2'b00, 12'h000, 32'h0, 1'b0, 12'h000);
      drive(2'b00, 12'h000, 32'h0, 1'b0, 12'h000);
      @(negedge CLK);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/approx_csr_bank.md
APPROX_CSR_BANK -- requirements
Module: approx_csr_bank

Interface
REQ-001 The block SHALL take parameter N_CSR, default 3: the number of approximation control CSRs, legal range 1..16.
REQ-002 The block SHALL take parameter BASE_INDEX, default 12'h800: the index of CSR 0; CSR k sits at BASE_INDEX+k.
REQ-003 The block SHALL take parameter XLEN, default 32: the CSR data width.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port read_enable_csr, input, 1 bit: read access qualifier.
REQ-007 The block SHALL have port csr_read_index, input, 12 bits: read address.
REQ-008 The block SHALL have port csr_read_data, output, XLEN bits: read result.
REQ-009 The block SHALL have port csr_op, input, 2 bits: 00 none, 01 write, 10 set bits, 11 clear bits.
REQ-010 The block SHALL have port csr_write_index, input, 12 bits: write address.
REQ-011 The block SHALL have port csr_write_data, input, XLEN bits: write, set or clear operand.
REQ-012 The block SHALL have port instret_inc, input, 1 bit: one instruction retired this cycle.
REQ-013 The block SHALL have port csr_bank_out, output, N_CSR*XLEN bits: all control CSRs flattened, with CSR k at bits [k*XLEN +: XLEN].
REQ-014 The block SHALL have port csr_illegal, output, 1 bit: registered illegal-access pulse.

Function
REQ-015 Reads SHALL be combinational: with read_enable_csr=1 and a mapped index, csr_read_data SHALL equal the current register value; otherwise it SHALL be 0, never Z.
REQ-016 Writes SHALL update on the rising edge of CLK: op 01 new=data; op 10 new=old|data; op 11 new=old&~data.
REQ-017 A read and a write to the same index in the same cycle SHALL return the pre-write value; the new value SHALL be visible the next cycle.
REQ-018 csr_bank_out SHALL be driven directly from the registers, with no extra latency beyond the write edge.
REQ-019 csr_illegal SHALL pulse high for exactly one cycle, on the cycle after any of: csr_op!=00 to an unmapped index; read_enable_csr=1 to an unmapped index; op 01 to a read-only index.
REQ-020 Ops 10 and 11 to a read-only index SHALL be legal only when csr_write_data=0, and SHALL perform no write.
REQ-021 An illegal write SHALL leave all state unchanged.
REQ-022 Indices outside BASE_INDEX..BASE_INDEX+N_CSR-1 and outside the counter map (REQ-028) SHALL be unmapped.

Reset
REQ-023 When reset=0, all control CSRs, both counters and csr_illegal SHALL clear to 0 immediately, independent of CLK.
REQ-024 While reset=0, csr_bank_out SHALL read all zeros.
REQ-025 A write presented during reset SHALL be discarded.
REQ-026 The first update after reset deasserts SHALL occur on the next rising edge of CLK.

Configuration
REQ-027 Macro APPROX_CSR_COUNTERS_EN, when defined, SHALL compile in two 64-bit read-only counters, cycle and instret.
REQ-028 With the macro defined: cycle SHALL increment every cycle; instret SHALL increment when instret_inc=1; cycle low/high SHALL map to 12'hC00/12'hC80 and instret low/high to 12'hC02/12'hC82 (XLEN=32; for XLEN=64 the low index returns the full counter and the high index is unmapped).
REQ-029 Both counters SHALL wrap from 2^64-1 to 0.
REQ-030 Without the macro, the counter logic SHALL be absent and indices C00/C80/C02/C82 SHALL be unmapped.

Verification
REQ-031 The bench SHALL check: reset low, then high; op 01 idx 800 data 0000_00F0; next cycle op 10 data 0000_000F -> read 800 = 0000_00FF, csr_bank_out[31:0]=0000_00FF.
REQ-032 The bench SHALL check: op 11 idx 800 data 0000_0003 plus same-cycle read of 800 -> read = 0000_00FF that cycle, 0000_00FC the next.
REQ-033 The bench SHALL check: op 01 idx 803 with N_CSR=3 -> csr_illegal=1 for one cycle; all CSRs unchanged; read 803 = 0.
REQ-034 The bench SHALL check, with APPROX_CSR_COUNTERS_EN: preload cycle to 0000_0000_FFFF_FFFF via force, then one clock -> read C00 = 0, read C80 = 1; op 01 to C00 -> csr_illegal pulse.
REQ-035 The bench SHALL check: reset dropped asynchronously mid-cycle after writing 801 = DEAD_BEEF -> csr_bank_out clears before the next edge and read 801 = 0.
